// File: rtl/peripheral_apb4_arbiter.sv
// rtl/peripheral_apb4_arbiter.sv - round-robin N-requester APB4 master arbiter/sequencer
//
// Ports:
//   PCLK, PRESET          clock, synchronous active-high reset
//   req/req_write         per-requester request (held until done) and direction
//   req_addr/req_wdata    packed per-requester address/write data (slot i at [i*W +: W])
//   done                  one-hot, one-cycle completion pulse to the granted requester
//   rsp_rdata/rsp_err     read data / error of the last completed transfer
//   PADDR..PWDATA         APB4 master outputs (all registered)
//   PRDATA/PREADY/PSLVERR APB4 slave responses
//
// Optional: define PERIPHERAL_APB4_ARBITER_TIMEOUT_EN to force an error completion
// after TIMEOUT wait-stated ACCESS cycles; otherwise ACCESS waits for PREADY forever.

module peripheral_apb4_arbiter #(
  parameter int NREQ    = 2,
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 16
) (
  input  logic               PCLK,
  input  logic               PRESET,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ-1:0]    req_write,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_wdata,
  output logic [NREQ-1:0]    done,
  output logic [DW-1:0]      rsp_rdata,
  output logic               rsp_err,
  output logic [AW-1:0]      PADDR,
  output logic               PWRITE,
  output logic               PSEL,
  output logic               PENABLE,
  output logic [DW-1:0]      PWDATA,
  input  logic [DW-1:0]      PRDATA,
  input  logic               PREADY,
  input  logic               PSLVERR
);

  localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } state_e;

  state_e          state_q, state_d;
  logic [GW-1:0]   grant_q, grant_d;
  logic [GW-1:0]   rr_q, rr_d;
  logic [AW-1:0]   paddr_q, paddr_d;
  logic            pwrite_q, pwrite_d;
  logic [DW-1:0]   pwdata_q, pwdata_d;
  logic            psel_q, psel_d;
  logic            penable_q, penable_d;
  logic [NREQ-1:0] done_q, done_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic            err_q, err_d;

`ifdef PERIPHERAL_APB4_ARBITER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0]   cnt_q, cnt_d;
`else
  logic            unused_timeout;
  assign unused_timeout = (TIMEOUT > 0);
`endif

  // Unpacked views of the packed requester buses, indexed by the grant.
  logic [AW-1:0]   addr_arr  [NREQ];
  logic [DW-1:0]   wdata_arr [NREQ];

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      addr_arr[i]  = req_addr[i*AW +: AW];
      wdata_arr[i] = req_wdata[i*DW +: DW];
    end
  end

  // Round-robin pick. A requester in its own done cycle is masked so it
  // cannot be re-granted before it has had a chance to drop req.
  logic [NREQ-1:0] eligible;
  logic [NREQ-1:0] rot;
  logic            found;
  logic [GW-1:0]   pick;
  int              idx_v;

  assign eligible = req & ~done_q;

  always_comb begin
    rot   = NREQ'({eligible, eligible} >> rr_q);
    found = 1'b0;
    pick  = '0;
    idx_v = 0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && rot[k]) begin
        found = 1'b1;
        idx_v = int'(rr_q) + k;
        if (idx_v >= NREQ) begin
          idx_v = idx_v - NREQ;
        end
        pick  = GW'(idx_v);
      end
    end
  end

  logic fin;
  logic fin_err;
  int   nxt_v;

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    rr_d      = rr_q;
    paddr_d   = paddr_q;
    pwrite_d  = pwrite_q;
    pwdata_d  = pwdata_q;
    psel_d    = psel_q;
    penable_d = penable_q;
    done_d    = '0;
    rdata_d   = rdata_q;
    err_d     = err_q;
    fin       = 1'b0;
    fin_err   = 1'b0;
    nxt_v     = 0;
`ifdef PERIPHERAL_APB4_ARBITER_TIMEOUT_EN
    cnt_d     = cnt_q;
`endif

    case (state_q)
      IDLE: begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
        if (found) begin
          grant_d  = pick;
          paddr_d  = addr_arr[pick];
          pwrite_d = req_write[pick];
          pwdata_d = wdata_arr[pick];
          psel_d   = 1'b1;
          state_d  = SETUP;
        end
      end

      SETUP: begin
        penable_d = 1'b1;
        state_d   = ACCESS;
`ifdef PERIPHERAL_APB4_ARBITER_TIMEOUT_EN
        cnt_d     = '0;
`endif
      end

      ACCESS: begin
        if (PREADY) begin
          fin     = 1'b1;
          fin_err = PSLVERR;
          if (!pwrite_q) begin
            rdata_d = PRDATA;
          end
        end
`ifdef PERIPHERAL_APB4_ARBITER_TIMEOUT_EN
        // The cycle whose increment would reach TIMEOUT is the last one
        // allowed, so the error completion lands after TIMEOUT wait cycles.
        else if (cnt_q == CW'(TIMEOUT - 1)) begin
          fin     = 1'b1;
          fin_err = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
        if (fin) begin
          psel_d    = 1'b0;
          penable_d = 1'b0;
          done_d    = NREQ'(1) << grant_q;
          err_d     = fin_err;
          nxt_v     = int'(grant_q) + 1;
          if (nxt_v >= NREQ) begin
            nxt_v = 0;
          end
          rr_d      = GW'(nxt_v);
          state_d   = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      rr_q      <= '0;
      paddr_q   <= '0;
      pwrite_q  <= 1'b0;
      pwdata_q  <= '0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      done_q    <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
`ifdef PERIPHERAL_APB4_ARBITER_TIMEOUT_EN
      cnt_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      rr_q      <= rr_d;
      paddr_q   <= paddr_d;
      pwrite_q  <= pwrite_d;
      pwdata_q  <= pwdata_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      done_q    <= done_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
`ifdef PERIPHERAL_APB4_ARBITER_TIMEOUT_EN
      cnt_q     <= cnt_d;
`endif
    end
  end

  assign PADDR     = paddr_q;
  assign PWRITE    = pwrite_q;
  assign PWDATA    = pwdata_q;
  assign PSEL      = psel_q;
  assign PENABLE   = penable_q;
  assign done      = done_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule
